// File: rtl/vga_pkg.sv
// vga_pkg: constants shared by the picture-overlay block.
//   - scale_e      : zoom encoding carried on the 2-bit scale input
//   - scale_shift  : maps the zoom code to a coordinate shift (0, 1 or 2)
//   - H_VALID_DEF / V_VALID_DEF : default active display size (640x480)
package vga_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

  typedef enum logic [1:0] {
    SCALE_X1   = 2'd0,
    SCALE_X2   = 2'd1,
    SCALE_X4   = 2'd2,
    SCALE_RSVD = 2'd3
  } scale_e;

  // The reserved code falls back to unity zoom.
  function automatic logic [1:0] scale_shift(input logic [1:0] scale);
    case (scale_e'(scale))
      SCALE_X2: return 2'd1;
      SCALE_X4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pic_ram.sv
// pic_ram: simple dual-port picture store, single clock.
//   clk     : clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data (one cycle after rd_addr)
// A read and a write to the same address in one cycle return the old word.
// The array has no reset so it maps onto block RAM; contents survive reset.
module pic_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_pic_overlay.sv
// vga_pic_overlay: overlays a stored PIC_H x PIC_V picture on the VGA
// active area at (pic_x0, pic_y0) with x1/x2/x4 zoom; background elsewhere.
//
// Ports:
//   vga_clk          : clock
//   sys_rst          : asynchronous active-high reset
//   pix_x, pix_y     : active-area coordinate of the current pixel
//   pic_x0, pic_y0   : top-left corner of the picture window
//   scale            : zoom code (0=x1, 1=x2, 2=x4, 3=x1)
//   wr_data/wr_valid : picture load stream, one pixel per valid cycle
//   wr_sof           : marks the first pixel of a load (restarts at address 0)
//   frame_end        : pulse after the last active pixel of a frame
//   pix_data         : registered output pixel, 2 cycles after pix_x/pix_y
//   wr_done          : pulse the cycle after the last picture pixel is written
//
// Build option VGA_PIC_DOUBLE_BUF_EN: two banks; loads go to the back bank and
// the front bank is swapped at the first frame_end after a completed load.
// Without it a single bank is used, loads show up immediately and frame_end
// is ignored.
module vga_pic_overlay
  import vga_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int PIC_H   = 128,
  parameter int PIC_V   = 128,
  parameter int H_VALID = H_VALID_DEF,
  parameter int V_VALID = V_VALID_DEF,
  parameter logic [PIX_W-1:0] BKG_COLOR = '1
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic [9:0]       pic_x0,
  input  logic [9:0]       pic_y0,
  input  logic [1:0]       scale,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_valid,
  input  logic             wr_sof,
  input  logic             frame_end,
  output logic [PIX_W-1:0] pix_data,
  output logic             wr_done
);

  localparam int DEPTH = PIC_H * PIC_V;
  localparam int AW    = $clog2(DEPTH);
  localparam int HB    = $clog2(PIC_H);
  localparam int LAST  = DEPTH - 1;

`ifdef VGA_PIC_DOUBLE_BUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  // ---------------------------------------------------------------- read side
  logic [1:0]  shift;
  logic [10:0] win_w;
  logic [10:0] win_h;
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic        hit;
  logic        hit_d;
  logic [AW-1:0] rd_addr;
  logic [PIX_W-1:0] ram_q;

  assign shift = scale_shift(scale);
  assign win_w = 11'(PIC_H) << shift;
  assign win_h = 11'(PIC_V) << shift;
  // 11-bit window ends so a window near the right/bottom edge cannot wrap.
  assign x_end = {1'b0, pic_x0} + win_w;
  assign y_end = {1'b0, pic_y0} + win_h;

  assign hit = ({1'b0, pix_x} >= {1'b0, pic_x0}) && ({1'b0, pix_x} < x_end) &&
               ({1'b0, pix_y} >= {1'b0, pic_y0}) && ({1'b0, pix_y} < y_end) &&
               ({1'b0, pix_x} < 11'(H_VALID)) && ({1'b0, pix_y} < 11'(V_VALID));

  assign dx = pix_x - pic_x0;
  assign dy = pix_y - pic_y0;
  // row * PIC_H as a shift; address is only meaningful when hit is set.
  assign rd_addr = AW'(({22'd0, dy} >> shift) << HB) + AW'({22'd0, dx} >> shift);

  // ---------------------------------------------------------------- write side
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] wr_at;
  logic          wr_last;

  // wr_sof with a valid pixel writes that pixel at address 0.
  assign wr_at   = wr_sof ? '0 : wr_addr;
  assign wr_last = (wr_at == AW'(LAST));

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_addr <= '0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= wr_valid && wr_last;
      if (wr_valid) begin
        wr_addr <= wr_last ? '0 : wr_at + 1'b1;
      end else if (wr_sof) begin
        wr_addr <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- banks
  logic [NBANK-1:0] bank_we;
  logic [PIX_W-1:0] bank_q [NBANK];

`ifdef VGA_PIC_DOUBLE_BUF_EN
  logic front;
  logic front_d;
  logic swap_pending;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      front        <= 1'b0;
      front_d      <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      // front_d follows the bank that was actually read, aligned with ram data.
      front_d <= front;
      // A wr_done coinciding with frame_end swaps at once; repeated wr_done
      // pulses before the swap collapse into one pending swap.
      if (frame_end && (swap_pending || wr_done)) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if (wr_done) begin
        swap_pending <= 1'b1;
      end
    end
  end

  assign bank_we[0] = wr_valid & front;
  assign bank_we[1] = wr_valid & ~front;
  assign ram_q      = front_d ? bank_q[1] : bank_q[0];
`else
  logic unused_frame_end;

  assign unused_frame_end = frame_end;
  assign bank_we[0]       = wr_valid;
  assign ram_q            = bank_q[0];
`endif

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    pic_ram #(
      .DW    (PIX_W),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_pic_ram (
      .clk     (vga_clk),
      .we      (bank_we[gi]),
      .wr_addr (wr_at),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (bank_q[gi])
    );
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hit_d    <= 1'b0;
      pix_data <= BKG_COLOR;
    end else begin
      hit_d    <= hit;
      pix_data <= hit_d ? ram_q : BKG_COLOR;
    end
  end

endmodule

// File: doc/vga_pic_overlay.md
VGA_PIC_OVERLAY -- requirements
Module: vga_pic_overlay

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning pixel width (RGB332 at 8).
REQ-002 SHALL have parameter PIC_H, default 128, meaning stored picture width in pixels (power of two).
REQ-003 SHALL have parameter PIC_V, default 128, meaning stored picture height in lines.
REQ-004 SHALL have parameter H_VALID, default 640, meaning active display width.
REQ-005 SHALL have parameter V_VALID, default 480, meaning active display height.
REQ-006 SHALL have parameter BKG_COLOR, default all-ones, meaning colour outside the picture window.
REQ-007 SHALL have port vga_clk, input, 1, the single clock; one clock; reset is asynchronous and active-high.
REQ-008 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have ports pix_x / pix_y, input, 10 each, active-area coordinate of the current pixel.
REQ-010 SHALL have ports pic_x0 / pic_y0, input, 10 each, top-left window position, sampled every cycle.
REQ-011 SHALL have port scale, input, 2, zoom: 0=x1, 1=x2, 2=x4, 3 treated as x1.
REQ-012 SHALL have ports wr_data (input, PIX_W), wr_valid (input, 1) and wr_sof (input, 1), the picture load stream; wr_sof marks the first pixel.
REQ-013 SHALL have port frame_end, input, 1, single-cycle pulse after the last active pixel of a frame.
REQ-014 SHALL have port pix_data, output, PIX_W, registered display pixel.
REQ-015 SHALL have port wr_done, output, 1, single-cycle pulse when pixel PIC_H*PIC_V-1 is written.

Function
REQ-016 SHALL derive shift s = 0/1/2 from scale and window size W = PIC_H<<s, Hh = PIC_V<<s.
REQ-017 SHALL assert hit when pic_x0 <= pix_x < pic_x0+W, pic_y0 <= pix_y < pic_y0+Hh, pix_x < H_VALID and pix_y < V_VALID; all comparisons are 11 bits wide so there is no wrap.
REQ-018 SHALL compute rd_addr = ((pix_y-pic_y0)>>s)*PIC_H + ((pix_x-pic_x0)>>s), with the multiply done as a shift.
REQ-019 SHALL read memory synchronously (1 cycle) and delay hit by one cycle to align with the read data.
REQ-020 SHALL register pix_data = hit_d ? ram_q : BKG_COLOR, giving a fixed latency of 2 vga_clk cycles from pix_x/pix_y to pix_data.
REQ-021 SHALL write wr_data to wr_addr on every wr_valid cycle, then increment wr_addr.
REQ-022 SHALL handle wr_sof: with wr_valid it writes address 0 and sets wr_addr to 1; without wr_valid it sets wr_addr to 0.
REQ-023 SHALL wrap wr_addr to 0 after PIC_H*PIC_V-1 and pulse wr_done in the cycle following that write.
REQ-024 SHALL let a write and a read to the same address in the same cycle return the old data.
REQ-025 SHALL ignore wr_valid when PIX_W data is X-free only by design; no error detection is required.

Reset
REQ-026 SHALL asynchronously reset wr_addr=0, hit_d=0, wr_done=0, pix_data=BKG_COLOR and all bank state to bank 0 displayed.
REQ-027 SHALL, when reset is asserted mid-load, discard the partial picture progress; the next load restarts at address 0 and the memory contents are not cleared.

Configuration
REQ-028 SHALL support macro VGA_PIC_DOUBLE_BUF_EN; when defined, it instantiates two banks, writes the back bank and reads the front bank.
REQ-029 SHALL, with VGA_PIC_DOUBLE_BUF_EN defined, set swap_pending on wr_done and toggle the front bank on frame_end while swap_pending is set, clearing swap_pending.
REQ-030 SHALL, with VGA_PIC_DOUBLE_BUF_EN defined, swap in the same cycle when wr_done and frame_end coincide; a second wr_done before the swap keeps a single pending swap.
REQ-031 SHALL, without VGA_PIC_DOUBLE_BUF_EN, use one bank, make writes visible immediately (tearing permitted) and ignore frame_end.

Structure
REQ-032 SHALL place the scale encoding constants and the default H_VALID/V_VALID in shared package vga_pkg.
REQ-033 SHALL implement the memory as sub-module pic_ram: simple dual-port, single clock, synchronous read, depth PIC_H*PIC_V per bank.

Verification
REQ-034 SHALL cover: x0=256, y0=176, scale=0, loaded ramp data[i]=i[7:0]; pixel (256,176) -> pix_data=0x00 two cycles later, (383,176) -> 0x7F, (384,176) -> 0xFF.
REQ-035 SHALL cover: scale=1, x0=y0=0; pixels (0,0),(1,0),(0,1),(1,1) -> all data[0]; (2,0) -> data[1]; (0,2) -> data[128].
REQ-036 SHALL cover: x0=600, scale=0; pixels at x=600..639 show picture; no hit beyond x=639 and no wrap to x=0.
REQ-037 SHALL cover: 16384 wr_valid pulses -> single wr_done pulse and wr_addr=0; wr_sof asserted mid-load -> next pixel is written at address 0.
REQ-038 SHALL cover, with VGA_PIC_DOUBLE_BUF_EN defined: load B during display of A -> output unchanged until the first frame_end after wr_done, then B; coincident wr_done and frame_end -> swap in that cycle.
REQ-039 SHALL cover: sys_rst asserted mid-load and mid-line -> pix_data=BKG_COLOR immediately and wr_addr=0.
